// File: rtl/ex_pkg.sv
// Shared encodings for the execute-stage ALU decoder: ALU/MDU op codes,
// MIPS opcode/funct constants and the execute result select.
package ex_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluSllv = 4'd11,
    AluSrlv = 4'd12,
    AluSrav = 4'd13,
    AluLui  = 4'd14
  } alu_op_e;

  typedef enum logic [4:0] {
    MduNone  = 5'd0,
    MduMult  = 5'd1,
    MduMultu = 5'd2,
    MduDiv   = 5'd3,
    MduDivu  = 5'd4,
    MduMfhi  = 5'd5,
    MduMflo  = 5'd6,
    MduMthi  = 5'd7,
    MduMtlo  = 5'd8
  } mdu_op_e;

  localparam logic [1:0] ESelAlu = 2'd0;
  localparam logic [1:0] ESelMdu = 2'd1;

  localparam logic [4:0] LinkReg = 5'd31;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpSltiu   = 6'h0b;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2b;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv  = 6'h06;
  localparam logic [5:0] FnSrav  = 6'h07;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnJalr  = 6'h09;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;
  localparam logic [5:0] FnSlt   = 6'h2a;
  localparam logic [5:0] FnSltu  = 6'h2b;

  function automatic logic is_mdu_start(input mdu_op_e op);
    return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Purely combinational 32-bit ALU for the execute stage; no overflow traps.
module ex_alu
  import ex_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      AluNor:  result_o = ~(a_i | b_i);
      AluSlt:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      AluSltu: result_o = {31'b0, a_i < b_i};
      AluSll:  result_o = b_i << shamt_i;
      AluSrl:  result_o = b_i >> shamt_i;
      AluSra:  result_o = $unsigned($signed(b_i) >>> shamt_i);
      AluSllv: result_o = b_i << a_i[4:0];
      AluSrlv: result_o = b_i >> a_i[4:0];
      AluSrav: result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      AluLui:  result_o = {b_i[15:0], 16'h0};
      default: result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/ex_alu_decode.sv
// Execute stage: instruction decode, ALU and the EX/MEM pipeline register.
// Define EX_MDU_DECODE_EN to decode mult/div/mfhi/mflo/mthi/mtlo; otherwise they act as nop.
module ex_alu_decode
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [31:0] RData1,
  input  logic [31:0] RData2,
  input  logic [31:0] Imm,
  input  logic        En,
  output logic [4:0]  ReadA1,
  output logic [4:0]  ReadA2,
  output logic [4:0]  WriteA,
  output logic [31:0] ALUResult,
  output logic [4:0]  MDUOp,
  output logic        MDUStart,
  output logic [1:0]  EResultSel,
  output logic [31:0] M_Instr,
  output logic [31:0] M_ALUResult,
  output logic [31:0] M_RData2,
  output logic [4:0]  M_WriteA
);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;

  assign opcode = Instr[31:26];
  assign rs     = Instr[25:21];
  assign rt     = Instr[20:16];
  assign rd     = Instr[15:11];
  assign shamt  = Instr[10:6];
  assign funct  = Instr[5:0];

  logic       alu_src;
  alu_op_e    alu_op;
  mdu_op_e    mdu_op;
  logic [4:0] read_a1, read_a2, write_a;

  always_comb begin
    alu_src = 1'b0;
    alu_op  = AluAdd;
    mdu_op  = MduNone;
    read_a1 = '0;
    read_a2 = '0;
    write_a = '0;
    case (opcode)
      OpSpecial: begin
        case (funct)
          FnSll:   begin alu_op = AluSll;  read_a2 = rt; write_a = rd; end
          FnSrl:   begin alu_op = AluSrl;  read_a2 = rt; write_a = rd; end
          FnSra:   begin alu_op = AluSra;  read_a2 = rt; write_a = rd; end
          FnSllv:  begin alu_op = AluSllv; read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnSrlv:  begin alu_op = AluSrlv; read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnSrav:  begin alu_op = AluSrav; read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnAdd, FnAddu: begin alu_op = AluAdd; read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnSub, FnSubu: begin alu_op = AluSub; read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnAnd:   begin alu_op = AluAnd;  read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnOr:    begin alu_op = AluOr;   read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnXor:   begin alu_op = AluXor;  read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnNor:   begin alu_op = AluNor;  read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnSlt:   begin alu_op = AluSlt;  read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnSltu:  begin alu_op = AluSltu; read_a1 = rs; read_a2 = rt; write_a = rd; end
          FnJr:    read_a1 = rs;
          FnJalr:  begin read_a1 = rs; write_a = rd; end
`ifdef EX_MDU_DECODE_EN
          FnMult:  begin mdu_op = MduMult;  read_a1 = rs; read_a2 = rt; end
          FnMultu: begin mdu_op = MduMultu; read_a1 = rs; read_a2 = rt; end
          FnDiv:   begin mdu_op = MduDiv;   read_a1 = rs; read_a2 = rt; end
          FnDivu:  begin mdu_op = MduDivu;  read_a1 = rs; read_a2 = rt; end
          FnMthi:  begin mdu_op = MduMthi;  read_a1 = rs; end
          FnMtlo:  begin mdu_op = MduMtlo;  read_a1 = rs; end
          FnMfhi:  begin mdu_op = MduMfhi;  write_a = rd; end
          FnMflo:  begin mdu_op = MduMflo;  write_a = rd; end
`endif
          default: ;
        endcase
      end
      OpAddi, OpAddiu: begin alu_src = 1'b1; alu_op = AluAdd;  read_a1 = rs; write_a = rt; end
      OpSlti:          begin alu_src = 1'b1; alu_op = AluSlt;  read_a1 = rs; write_a = rt; end
      OpSltiu:         begin alu_src = 1'b1; alu_op = AluSltu; read_a1 = rs; write_a = rt; end
      OpAndi:          begin alu_src = 1'b1; alu_op = AluAnd;  read_a1 = rs; write_a = rt; end
      OpOri:           begin alu_src = 1'b1; alu_op = AluOr;   read_a1 = rs; write_a = rt; end
      OpXori:          begin alu_src = 1'b1; alu_op = AluXor;  read_a1 = rs; write_a = rt; end
      OpLui:           begin alu_src = 1'b1; alu_op = AluLui;  write_a = rt; end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
        alu_src = 1'b1;
        read_a1 = rs;
        write_a = rt;
      end
      OpSb, OpSh, OpSw: begin
        alu_src = 1'b1;
        read_a1 = rs;
        read_a2 = rt;
      end
      OpBeq, OpBne:    begin read_a1 = rs; read_a2 = rt; end
      OpBlez, OpBgtz:  read_a1 = rs;
      OpJal:           write_a = LinkReg;
      default: ;
    endcase
  end

  ex_alu u_alu (
    .a_i      (RData1),
    .b_i      (alu_src ? Imm : RData2),
    .shamt_i  (shamt),
    .op_i     (alu_op),
    .result_o (ALUResult)
  );

  assign ReadA1     = read_a1;
  assign ReadA2     = read_a2;
  assign WriteA     = write_a;
  assign MDUOp      = mdu_op;
  assign MDUStart   = is_mdu_start(mdu_op);
  assign EResultSel = ((mdu_op == MduMfhi) || (mdu_op == MduMflo)) ? ESelMdu : ESelAlu;

  logic [31:0] m_instr_d, m_instr_q, m_alu_result_d, m_alu_result_q;
  logic [31:0] m_rdata2_d, m_rdata2_q;
  logic [4:0]  m_write_a_d, m_write_a_q;

  always_comb begin
    m_instr_d      = m_instr_q;
    m_alu_result_d = m_alu_result_q;
    m_rdata2_d     = m_rdata2_q;
    m_write_a_d    = m_write_a_q;
    if (En) begin
      m_instr_d      = Instr;
      m_alu_result_d = ALUResult;
      m_rdata2_d     = RData2;
      m_write_a_d    = write_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_instr_q      <= '0;
      m_alu_result_q <= '0;
      m_rdata2_q     <= '0;
      m_write_a_q    <= '0;
    end else begin
      m_instr_q      <= m_instr_d;
      m_alu_result_q <= m_alu_result_d;
      m_rdata2_q     <= m_rdata2_d;
      m_write_a_q    <= m_write_a_d;
    end
  end

  assign M_Instr     = m_instr_q;
  assign M_ALUResult = m_alu_result_q;
  assign M_RData2    = m_rdata2_q;
  assign M_WriteA    = m_write_a_q;

endmodule

// File: tb/tb_ex_alu_decode.sv
// Bench for ex_alu_decode: directed cases plus random instructions checked against
// a mnemonic-level reference model. Honors EX_MDU_DECODE_EN like the design.
module tb_ex_alu_decode;

`ifdef EX_MDU_DECODE_EN
  localparam bit MduOn = 1'b1;
`else
  localparam bit MduOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, En;
  logic [31:0] Instr, RData1, RData2, Imm;
  logic [4:0]  ReadA1, ReadA2, WriteA, MDUOp, M_WriteA;
  logic [31:0] ALUResult, M_Instr, M_ALUResult, M_RData2;
  logic        MDUStart;
  logic [1:0]  EResultSel;

  always #5 clk = ~clk;

  ex_alu_decode dut (
    .clk         (clk),
    .reset       (reset),
    .Instr       (Instr),
    .RData1      (RData1),
    .RData2      (RData2),
    .Imm         (Imm),
    .En          (En),
    .ReadA1      (ReadA1),
    .ReadA2      (ReadA2),
    .WriteA      (WriteA),
    .ALUResult   (ALUResult),
    .MDUOp       (MDUOp),
    .MDUStart    (MDUStart),
    .EResultSel  (EResultSel),
    .M_Instr     (M_Instr),
    .M_ALUResult (M_ALUResult),
    .M_RData2    (M_RData2),
    .M_WriteA    (M_WriteA)
  );

  typedef struct packed {
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] res;
    logic [4:0]  mop;
    logic        mstart;
    logic [1:0]  esel;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t        cur;
  logic [31:0] em_instr, em_res, em_rd2;
  logic [4:0]  em_wa;

  function automatic string name_of(input logic [31:0] ins);
    string nm;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    nm = "nop";
    if (op == 6'd0) begin
      case (fn)
        6'd0: nm = "sll";    6'd2: nm = "srl";    6'd3: nm = "sra";
        6'd4: nm = "sllv";   6'd6: nm = "srlv";   6'd7: nm = "srav";
        6'd8: nm = "jr";     6'd9: nm = "jalr";
        6'd16: nm = "mfhi";  6'd17: nm = "mthi";  6'd18: nm = "mflo";  6'd19: nm = "mtlo";
        6'd24: nm = "mult";  6'd25: nm = "multu"; 6'd26: nm = "div";   6'd27: nm = "divu";
        6'd32: nm = "add";   6'd33: nm = "addu";  6'd34: nm = "sub";   6'd35: nm = "subu";
        6'd36: nm = "and";   6'd37: nm = "or";    6'd38: nm = "xor";   6'd39: nm = "nor";
        6'd42: nm = "slt";   6'd43: nm = "sltu";
        default: nm = "nop";
      endcase
    end else begin
      case (op)
        6'd2: nm = "j";      6'd3: nm = "jal";    6'd4: nm = "beq";    6'd5: nm = "bne";
        6'd6: nm = "blez";   6'd7: nm = "bgtz";   6'd8: nm = "addi";   6'd9: nm = "addiu";
        6'd10: nm = "slti";  6'd11: nm = "sltiu"; 6'd12: nm = "andi";  6'd13: nm = "ori";
        6'd14: nm = "xori";  6'd15: nm = "lui";
        6'd32: nm = "lb";    6'd33: nm = "lh";    6'd35: nm = "lw";    6'd36: nm = "lbu";
        6'd37: nm = "lhu";   6'd40: nm = "sb";    6'd41: nm = "sh";    6'd43: nm = "sw";
        default: nm = "nop";
      endcase
    end
    if (!MduOn) begin
      case (nm)
        "mult", "multu", "div", "divu", "mfhi", "mflo", "mthi", "mtlo": nm = "nop";
        default: ;
      endcase
    end
    return nm;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, a, b, imm);
    exp_t        e;
    string       nm = name_of(ins);
    logic [4:0]  rs = ins[25:21];
    logic [4:0]  rt = ins[20:16];
    logic [4:0]  rd = ins[15:11];
    int unsigned sh = ins[10:6];
    int unsigned sv = a[4:0];
    logic [31:0] bo;
    bit use_imm = 0, r_alu = 0, i_alu = 0, load = 0, store = 0;
    e = '0;
    case (nm)
      "add", "addu", "sub", "subu", "and", "or", "xor", "nor", "slt", "sltu",
      "sll", "srl", "sra", "sllv", "srlv", "srav": r_alu = 1;
      "addi", "addiu", "andi", "ori", "xori", "lui", "slti", "sltiu": i_alu = 1;
      "lb", "lh", "lw", "lbu", "lhu": load = 1;
      "sb", "sh", "sw": store = 1;
      default: ;
    endcase
    use_imm = i_alu || load || store;
    bo = use_imm ? imm : b;
    case (nm)
      "sub", "subu":   e.res = a - bo;
      "and", "andi":   e.res = a & bo;
      "or", "ori":     e.res = a | bo;
      "xor", "xori":   e.res = a ^ bo;
      "nor":           e.res = ~(a | bo);
      "slt", "slti":   e.res = ($signed(a) < $signed(bo)) ? 32'd1 : 32'd0;
      "sltu", "sltiu": e.res = (a < bo) ? 32'd1 : 32'd0;
      "sll":           e.res = bo << sh;
      "srl":           e.res = bo >> sh;
      "sra":           e.res = $unsigned($signed(bo) >>> sh);
      "sllv":          e.res = bo << sv;
      "srlv":          e.res = bo >> sv;
      "srav":          e.res = $unsigned($signed(bo) >>> sv);
      "lui":           e.res = bo * 32'h10000;
      default:         e.res = a + bo;
    endcase
    if ((r_alu && nm != "sll" && nm != "srl" && nm != "sra") || (i_alu && nm != "lui") ||
        load || store)
      e.ra1 = rs;
    case (nm)
      "beq", "bne", "blez", "bgtz", "jr", "jalr", "mult", "multu", "div", "divu",
      "mthi", "mtlo": e.ra1 = rs;
      default: ;
    endcase
    if (r_alu || store || nm == "beq" || nm == "bne" || nm == "mult" || nm == "multu" ||
        nm == "div" || nm == "divu")
      e.ra2 = rt;
    if (r_alu || nm == "jalr" || nm == "mfhi" || nm == "mflo") e.wa = rd;
    else if (i_alu || load) e.wa = rt;
    else if (nm == "jal") e.wa = 5'd31;
    case (nm)
      "mult":  e.mop = 5'd1;  "multu": e.mop = 5'd2;  "div":  e.mop = 5'd3;
      "divu":  e.mop = 5'd4;  "mfhi":  e.mop = 5'd5;  "mflo": e.mop = 5'd6;
      "mthi":  e.mop = 5'd7;  "mtlo":  e.mop = 5'd8;
      default: e.mop = 5'd0;
    endcase
    e.mstart = (e.mop >= 5'd1) && (e.mop <= 5'd4);
    e.esel   = (nm == "mfhi" || nm == "mflo") ? 2'd1 : 2'd0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic apply(input logic [31:0] ins, a, b, imm, input logic en, rst);
    @(negedge clk);
    Instr = ins; RData1 = a; RData2 = b; Imm = imm; En = en; reset = rst;
    #1;
    cur = model(ins, a, b, imm);
    check("ReadA1", {27'b0, ReadA1}, {27'b0, cur.ra1});
    check("ReadA2", {27'b0, ReadA2}, {27'b0, cur.ra2});
    check("WriteA", {27'b0, WriteA}, {27'b0, cur.wa});
    check("ALUResult", ALUResult, cur.res);
    check("MDUOp", {27'b0, MDUOp}, {27'b0, cur.mop});
    check("MDUStart", {31'b0, MDUStart}, {31'b0, cur.mstart});
    check("EResultSel", {30'b0, EResultSel}, {30'b0, cur.esel});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      em_instr = '0; em_res = '0; em_rd2 = '0; em_wa = '0;
    end else if (En) begin
      em_instr = Instr; em_res = cur.res; em_rd2 = RData2; em_wa = cur.wa;
    end
    #1;
    check("M_Instr", M_Instr, em_instr);
    check("M_ALUResult", M_ALUResult, em_res);
    check("M_RData2", M_RData2, em_rd2);
    check("M_WriteA", {27'b0, M_WriteA}, {27'b0, em_wa});
  endtask

  function automatic logic [31:0] rtype(input int rs, rt, rd, sh, fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] itype(input int op, rs, rt, input logic [15:0] im);
    return {op[5:0], rs[4:0], rt[4:0], im};
  endfunction

  logic [31:0] tmpl [$];

  initial begin
    Instr = '0; RData1 = '0; RData2 = '0; Imm = '0; En = 1'b0; reset = 1'b1;
    // Reset clears the memory-stage copies.
    apply(32'h0, 32'h5, 32'h6, 32'h7, 1'b1, 1'b1);
    tick();
    check("reset_M_Instr_zero", M_Instr, 32'h0);

    apply(rtype(1, 2, 3, 0, 33), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    check("addu_result", ALUResult, 32'h0);
    check("addu_wa", {27'b0, WriteA}, 32'd3);
    check("addu_ra1", {27'b0, ReadA1}, 32'd1);
    check("addu_ra2", {27'b0, ReadA2}, 32'd2);
    tick();

    apply(rtype(4, 5, 6, 0, 42), 32'h8000_0000, 32'h1, 32'h0, 1'b1, 1'b0);
    check("slt_signed", ALUResult, 32'h1);
    apply(rtype(4, 5, 6, 0, 43), 32'h8000_0000, 32'h1, 32'h0, 1'b1, 1'b0);
    check("sltu_unsigned", ALUResult, 32'h0);
    apply(rtype(0, 7, 8, 4, 3), 32'h0, 32'hF000_0000, 32'h0, 1'b1, 1'b0);
    check("sra_shamt4", ALUResult, 32'hFF00_0000);
    check("sra_ra1_zero", {27'b0, ReadA1}, 32'd0);
    apply(itype(15, 0, 9, 16'h1234), 32'h55, 32'h66, 32'h1234, 1'b1, 1'b0);
    check("lui_result", ALUResult, 32'h1234_0000);
    check("lui_wa_rt", {27'b0, WriteA}, 32'd9);
    apply({6'd3, 26'h0123456}, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0);
    check("jal_wa31", {27'b0, WriteA}, 32'd31);
    apply(itype(43, 4, 5, 16'h0010), 32'd100, 32'hDEAD, 32'h10, 1'b1, 1'b0);
    check("sw_wa0", {27'b0, WriteA}, 32'd0);
    check("sw_ra2_rt", {27'b0, ReadA2}, 32'd5);
    check("sw_addr", ALUResult, 32'd116);
    apply(rtype(10, 11, 0, 0, 24), 32'h3, 32'h4, 32'h0, 1'b1, 1'b0);
    check("mult_start", {31'b0, MDUStart}, MduOn ? 32'd1 : 32'd0);
    check("mult_op", {27'b0, MDUOp}, MduOn ? 32'd1 : 32'd0);
    apply(rtype(0, 0, 12, 0, 18), 32'h3, 32'h4, 32'h0, 1'b1, 1'b0);
    check("mflo_esel", {30'b0, EResultSel}, MduOn ? 32'd1 : 32'd0);
    check("mflo_wa", {27'b0, WriteA}, MduOn ? 32'd12 : 32'd0);

    // Load, hold with En=0, then reset overriding En.
    apply(rtype(1, 2, 3, 0, 35), 32'd50, 32'd8, 32'h0, 1'b1, 1'b0);
    tick();
    check("load_M_ALUResult", M_ALUResult, 32'd42);
    apply(rtype(4, 5, 6, 0, 33), 32'd1, 32'd1, 32'h0, 1'b0, 1'b0);
    tick();
    check("hold_M_ALUResult", M_ALUResult, 32'd42);
    check("hold_M_WriteA", {27'b0, M_WriteA}, 32'd3);
    apply(rtype(4, 5, 6, 0, 33), 32'd1, 32'd1, 32'h0, 1'b1, 1'b1);
    tick();
    check("rst_M_ALUResult", M_ALUResult, 32'd0);
    check("rst_M_Instr", M_Instr, 32'd0);

    foreach (dut.opcode[i]) ;
    for (int f = 0; f < 64; f++) tmpl.push_back({6'd0, 20'b0, f[5:0]});
    for (int o = 1; o < 64; o++) tmpl.push_back({o[5:0], 26'b0});
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins;
      int unsigned idx = $urandom_range(0, tmpl.size() - 1);
      if (tmpl[idx][31:26] == 6'd0) ins = tmpl[idx] | {6'd0, 20'($urandom), 6'd0};
      else ins = tmpl[idx] | {6'd0, 26'($urandom)};
      if ($urandom_range(0, 9) == 0) ins = $urandom;
      apply(ins, $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
